// File: rtl/keypad_scan_debounce.sv
// 4x4 matrix keypad front end. It drives one column low at a time, locks onto the first
// pressed key, and reports a debounced hex code with a level valid flag.
module keypad_scan_debounce #(
  parameter int unsigned SCAN_DIV        = 1200,
  parameter int unsigned DEBOUNCE_CYCLES = 240000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid
);

  localparam int unsigned CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_SCAN       = 2'd0,
    S_DB_PRESS   = 2'd1,
    S_HELD       = 2'd2,
    S_DB_RELEASE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_sync1;
  logic [3:0]       r_rs;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [1:0]       r_col;
  logic [1:0]       w_col_nxt;
  logic [1:0]       r_lrow;
  logic [1:0]       w_lrow_nxt;
  logic [3:0]       r_col_out;
  logic [3:0]       r_key_code;
  logic [3:0]       w_key_code_nxt;
  logic             r_key_valid;
  logic             w_key_valid_nxt;
  logic             w_any_low;
  logic [1:0]       w_low_row;
  logic             w_lrow_high;
  logic             w_scan_wrap;

  function automatic logic [3:0] f_key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  4'hF: code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  // Two-flop synchronizer. Idle rows read high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 4'hF;
      r_rs    <= 4'hF;
    end else begin
      r_sync1 <= row_in;
      r_rs    <= r_sync1;
    end
  end

  // Lowest-index low row wins when several keys share a column.
  always_comb begin
    w_low_row = 2'd3;
    if (!r_rs[0])      w_low_row = 2'd0;
    else if (!r_rs[1]) w_low_row = 2'd1;
    else if (!r_rs[2]) w_low_row = 2'd2;
  end

  assign w_any_low   = ~&r_rs;
  assign w_lrow_high = r_rs[r_lrow];
  assign w_scan_wrap = (r_state == S_SCAN) && (r_cnt == SCAN_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_SCAN;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_SCAN:       if (w_scan_wrap && w_any_low) w_state_nxt = S_DB_PRESS;
      S_DB_PRESS:   if (w_lrow_high)              w_state_nxt = S_SCAN;
                    else if (r_cnt == DB_LAST)    w_state_nxt = S_HELD;
      S_HELD:       if (w_lrow_high)              w_state_nxt = S_DB_RELEASE;
      S_DB_RELEASE: if (!w_lrow_high)             w_state_nxt = S_HELD;
                    else if (r_cnt == DB_LAST)    w_state_nxt = S_SCAN;
      default:                                    w_state_nxt = S_SCAN;
    endcase
  end

  // The locked column is r_col itself: the column only advances on a return to scanning.
  always_comb begin
    w_cnt_nxt       = r_cnt + CNT_W'(1);
    w_col_nxt       = r_col;
    w_lrow_nxt      = r_lrow;
    w_key_code_nxt  = r_key_code;
    w_key_valid_nxt = r_key_valid;
    if ((w_state_nxt != r_state) || w_scan_wrap || (r_state == S_HELD)) w_cnt_nxt = '0;
    if ((w_scan_wrap && !w_any_low) || ((w_state_nxt == S_SCAN) && (r_state != S_SCAN)))
      w_col_nxt = r_col + 2'd1;
    if (w_scan_wrap && w_any_low) w_lrow_nxt = w_low_row;
    if ((r_state == S_DB_PRESS) && (w_state_nxt == S_HELD)) begin
      w_key_code_nxt  = f_key_map(r_lrow, r_col);
      w_key_valid_nxt = 1'b1;
    end
    if ((r_state == S_DB_RELEASE) && (w_state_nxt == S_SCAN)) w_key_valid_nxt = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_col       <= 2'd0;
      r_lrow      <= 2'd0;
      r_col_out   <= 4'b1110;
      r_key_code  <= 4'h0;
      r_key_valid <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_col       <= w_col_nxt;
      r_lrow      <= w_lrow_nxt;
      r_col_out   <= ~(4'b0001 << w_col_nxt);
      r_key_code  <= w_key_code_nxt;
      r_key_valid <= w_key_valid_nxt;
    end
  end

  assign col_out   = r_col_out;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;

endmodule

// File: doc/keypad_scan_debounce.md
# keypad_scan_debounce

Column-scanning, debouncing front end for the 4x4 matrix keypad. It drives one keypad column low at a time, samples the active-low rows through a synchronizer, and locks onto the first pressed key. It debounces both press and release, then presents a stable hex `key_code` with a level `key_valid` that stays high for the whole held duration. It sits directly upstream of the one-shot key registration stage, which turns the rising edge of `key_valid` into a single new-key pulse.

## Interface
Parameters:
- `SCAN_DIV`, default 1200: clock cycles each column is driven before its rows are sampled (100 µs at 12 MHz). Must be ≥ 4.
- `DEBOUNCE_CYCLES`, default 240000: consecutive stable cycles required to confirm a press or a release (20 ms at 12 MHz). Must be ≥ 2.

Ports:
- `clk`  in  1: system clock (12 MHz internal oscillator).
- `rst`  in  1: asynchronous, active-high reset.
- `row_in`  in  4: keypad rows, active-low. Asynchronous to `clk`.
- `col_out`  out  4: keypad column drive, active-low, one-hot-low, registered.
- `key_code`  out  4: hex code of the confirmed key, registered.
- `key_valid`  out  1: high while a debounced key is held, registered.

## Operation
- `row_in` passes through a 2-flop synchronizer; all logic below uses the synchronized value `rs`.
- Key map, row r and column c, reading c = 0..3:
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: E, 0, F, D
- The FSM has four states: SCAN, DB_PRESS, HELD, DB_RELEASE. One shared counter `cnt`; its width is sized to the larger parameter.
- SCAN:
  - `cnt` counts 0..SCAN_DIV-1 with `col_out` = ~(1<<col).
  - At `cnt` = SCAN_DIV-1: if any `rs` bit is 0, latch `lrow` = lowest-index low row and `lcol` = col, clear `cnt`, go to DB_PRESS. The column is not advanced.
  - Otherwise col increments (3 wraps to 0) and `cnt` clears.
- DB_PRESS:
  - `rs[lrow]` = 1 (bounce): go to SCAN, advance col, clear `cnt`.
  - Otherwise `cnt`++. At `cnt` = DEBOUNCE_CYCLES-1: go to HELD, `key_code` <= map(`lrow`, `lcol`), `key_valid` <= 1.
- HELD:
  - `col_out` stays on `lcol`.
  - `rs[lrow]` = 1: go to DB_RELEASE, clear `cnt`.
  - Other rows are ignored, so a second key pressed while the first is held never registers.
- DB_RELEASE:
  - `rs[lrow]` = 0: return to HELD. `key_valid` stays 1.
  - Otherwise `cnt`++. At DEBOUNCE_CYCLES-1: `key_valid` <= 0, go to SCAN, advance col, clear `cnt`.
- `key_code` keeps its last value after release. It changes only on entry to HELD.
- Simultaneous keys in one column: the lowest row index wins. Keys in different columns: the one whose column is scanned first wins.

## Timing
- Reset values (immediate on `rst` rising): state SCAN, col 0, `col_out` = 4'b1110, `cnt` = 0, `key_code` = 4'h0, `key_valid` = 0, synchronizer flops = 4'b1111.
- Reset mid-press returns to SCAN. A key still held after reset is re-detected and re-debounced from scratch, giving one new `key_valid` rise.
- Sync latency is 2 cycles. It is hidden by SCAN_DIV ≥ 4, so a sample always reflects the current column.
- Press latency, from a stable low on the pin to the `key_valid` rise: at most 2 + 4·SCAN_DIV + DEBOUNCE_CYCLES + 1 cycles.
- Release latency, from a stable high on the pin to the `key_valid` fall: 2 + DEBOUNCE_CYCLES + 1 cycles.
- Each confirmed press produces exactly one 0→1 transition of `key_valid`. Bounces of up to DEBOUNCE_CYCLES-1 cycles cause no glitch on either edge.
- `col_out`, `key_code` and `key_valid` change only on `clk` rising edges, except under reset.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_CYCLES=8. The bench keypad model grounds row r whenever `col_out[c]` = 0 and key (r,c) is pressed.
- **Reset:** assert `rst` mid-cycle -> `col_out` = 1110, `key_valid` = 0, `key_code` = 0 at once. Release -> `col_out` steps 1110, 1101, 1011, 0111, 1110 every 4 cycles.
- **Single press:** press key (r1,c2) cleanly -> `key_valid` rises within 2+16+8+1 cycles with `key_code` = 4'h6. `col_out` stays 1011 while held. Release -> `key_valid` falls 11 cycles later and `key_code` stays 6.
- **Press bounce:** toggle (r3,c1) every 3 cycles for 30 cycles, then hold it -> no `key_valid` during bouncing. Exactly one rise, `key_code` = 4'h0.
- **Release bounce:** while (r0,c3) is held, release for 5 cycles, re-press for 2, then release for good -> `key_valid` stays 1 through the glitch and falls once; `key_code` = 4'hA.
- **Multi-key:** hold (r2,c0) and (r0,c0) together -> `key_code` = 4'h1. While held, add (r1,c3) -> no change. Release all -> one fall.
- **Full map:** press each of the 16 keys in turn -> each `key_code` matches the key map, with 16 `key_valid` rises in total.
